poly_eval_arbiter: RTL and testbench
====================================

// Module: poly_eval_arbiter
// PURPOSE
//  Shares one polynomial evaluator (en/done handshake, 3x4-bit in, 19-bit signed out) between N_REQ requesters.
//  Round-robin arbitration; captures the winner's operands and sequences the evaluator: setup, en, wait done, release.
//  Returns the result to the winner, or an error flag on timeout. Sits between client logic and the evaluator core.
// PARAMETERS
//  N_REQ    4   number of requesters (2..8)
//  IN_W     4   operand width per input (x,y,z)
//  OUT_W    19  evaluator result width, signed
//  TIMEOUT  64  max cycles in BUSY waiting for ev_done before abort (>=2)
// PORTS
//  clk        in   1              system clock, all logic on posedge
//  rst        in   1              synchronous reset, active-high
//  req        in   N_REQ          per-requester request level; held with operands until gnt
//  req_x      in   N_REQ*IN_W     operand x, requester i at [i*IN_W +: IN_W]
//  req_y      in   N_REQ*IN_W     operand y, same packing
//  req_z      in   N_REQ*IN_W     operand z, same packing
//  gnt        out  N_REQ          one-hot, 1-cycle pulse: request accepted, operands captured
//  rsp_valid  out  N_REQ          one-hot, 1-cycle pulse to the granted requester
//  rsp_data   out  OUT_W          signed result, valid with rsp_valid
//  rsp_err    out  1              qualifies rsp_valid: 1 = timeout, rsp_data = 0
//  busy       out  1              high in every state except IDLE
//  ev_en      out  1              evaluator enable
//  ev_in0/1/2 out  IN_W each      evaluator operands x/y/z, registered
//  ev_done    in   1              evaluator done level
//  ev_out     in   OUT_W          evaluator result, signed
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, timeout counter 0. Reset in any state aborts the job:
//   ev_en low on the next edge, no rsp_valid for the dropped job.
//  FSM, one transition per clock:
//   IDLE  : if |req, the rr winner is the first set bit at or after ptr, wrapping.
//           Latch the index and operands into ev_in*, pulse gnt[win] next cycle, ptr <= (win+1)%N_REQ -> SETUP.
//           If req==0, stay.
//   SETUP : ev_en=0 and operands stable for exactly 1 cycle -> BUSY.
//   BUSY  : ev_en=1 and ev_in* held constant; cnt increments each cycle.
//           On ev_done==1, capture ev_out -> RESP.
//           On cnt==TIMEOUT-1 without done -> RESP with err=1. Done wins if both occur in the same cycle.
//   RESP  : ev_en=0; rsp_valid[idx]=1 for 1 cycle; rsp_data = captured (or 0 on err); rsp_err set -> DRAIN.
//   DRAIN : ev_en=0; wait until ev_done==0 -> IDLE. Guarantees en is low >=2 cycles between jobs.
//  Latency: req seen in IDLE at edge t -> gnt high in cycle t+1 -> ev_en rises at t+2.
//   rsp_valid comes 1 cycle after the first ev_done sample.
//  Requesters drop req after seeing gnt. A req still high in RESP/DRAIN is simply re-arbitrated in IDLE.
//  A req withdrawn before IDLE samples it is never granted. Requests are ignored outside IDLE (no queueing).
//  rsp_data is the evaluator output passed unmodified (no resizing); sign is preserved.
//  At most one bit of gnt and of rsp_valid is set at any time.
// STRUCTURE
//  Shared package/header poly_arb_pkg: FSM state encoding (IDLE, SETUP, BUSY, RESP, DRAIN),
//   IN_W/OUT_W defaults, timeout counter width = $clog2(TIMEOUT).
//  Sub-module rr_arbiter: combinational first-set-at-or-after-ptr search plus the registered pointer,
//   update enabled by the FSM on grant. Everything else (FSM, operand/result registers, counter) lives in this top.
// TESTING  (evaluator model: F = 5x^2+8x-4y^2+3y+6z^2-2z+13, variable latency 3..10 cycles)
//  1. rst=1 for 3 cycles while req=4'hF -> all outputs 0, no gnt; after release, first gnt is gnt[0].
//  2. req[0] only, (1,0,0) -> one gnt[0] pulse, ev_in0=1, ev_en rises 2 cycles after sampling;
//     rsp_valid[0] with rsp_data=26, rsp_err=0.
//  3. req=4'hF at once: (0,0,0),(1,0,0),(3,2,1),(2,5,3) -> grant order 0,1,2,3; responses 13,26,76,12.
//  4. req[0] and req[2] held high permanently -> grants alternate 0,2,0,2; req[1]/req[3] never granted.
//  5. Evaluator stub never raises done -> exactly TIMEOUT cycles of ev_en=1, then rsp_valid with rsp_err=1,
//     rsp_data=0; FSM back in IDLE.
//  6. rst pulsed mid-BUSY on a (15,15,15) job -> ev_en=0 the next cycle, no rsp_valid, ptr=0;
//     a re-request returns 1723.

Source files
------------

// File: rtl/poly_arb_pkg.sv
// rtl/poly_arb_pkg.sv - FSM encoding and defaults shared by the evaluator arbiter
package poly_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_BUSY,
    ST_RESP,
    ST_DRAIN
  } arb_state_t;

  localparam int IN_W_DEF    = 4;
  localparam int OUT_W_DEF   = 19;
  localparam int TIMEOUT_DEF = 64;

  // Wide enough to hold TIMEOUT-1, the last BUSY cycle before abort
  function automatic int cnt_w(input int timeout);
    return $clog2(timeout);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first request at or after the pointer
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic             win_valid,
  output logic [IDX_W-1:0] win_idx
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   cand;

  // Scan from the farthest offset down so the nearest set bit is the last write
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(off);
      if (cand >= (IDX_W + 1)'(N_REQ)) begin
        cand = cand - (IDX_W + 1)'(N_REQ);
      end
      if (req[cand[IDX_W-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && win_valid) begin
      ptr <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

endmodule

// File: rtl/poly_eval_arbiter.sv
// rtl/poly_eval_arbiter.sv - shares one polynomial evaluator between N_REQ requesters
module poly_eval_arbiter
  import poly_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int IN_W    = IN_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*IN_W-1:0]   req_x,
  input  logic [N_REQ*IN_W-1:0]   req_y,
  input  logic [N_REQ*IN_W-1:0]   req_z,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic signed [OUT_W-1:0] rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    ev_en,
  output logic [IN_W-1:0]         ev_in0,
  output logic [IN_W-1:0]         ev_in1,
  output logic [IN_W-1:0]         ev_in2,
  input  logic                    ev_done,
  input  logic signed [OUT_W-1:0] ev_out
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = cnt_w(TIMEOUT);

  arb_state_t              state, state_nxt;
  logic [IDX_W-1:0]        idx_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [OUT_W-1:0] res_q;
  logic                    err_q;
  logic                    win_valid;
  logic [IDX_W-1:0]        win_idx;
  logic                    last_cycle;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .advance   (state == ST_IDLE),
    .win_valid (win_valid),
    .win_idx   (win_idx)
  );

  assign last_cycle = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    busy      = (state != ST_IDLE);
    ev_en     = 1'b0;
    case (state)
      ST_IDLE:  if (win_valid) state_nxt = ST_SETUP;
      ST_SETUP: begin
        gnt[idx_q] = 1'b1;
        state_nxt  = ST_BUSY;
      end
      ST_BUSY: begin
        ev_en = 1'b1;
        if (ev_done || last_cycle) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[idx_q] = 1'b1;
        rsp_data         = res_q;
        rsp_err          = err_q;
        state_nxt        = ST_DRAIN;
      end
      ST_DRAIN: if (!ev_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx_q  <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
      ev_in0 <= '0;
      ev_in1 <= '0;
      ev_in2 <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (win_valid) begin
          idx_q  <= win_idx;
          ev_in0 <= req_x[win_idx*IN_W +: IN_W];
          ev_in1 <= req_y[win_idx*IN_W +: IN_W];
          ev_in2 <= req_z[win_idx*IN_W +: IN_W];
        end
        ST_SETUP: cnt_q <= '0;
        // A done in the final allowed cycle still counts as success
        ST_BUSY: begin
          if (ev_done) begin
            res_q <= ev_out;
            err_q <= 1'b0;
          end else if (last_cycle) begin
            res_q <= '0;
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_eval_arbiter.sv
// tb/tb_poly_eval_arbiter.sv - scoreboard bench for poly_eval_arbiter with a variable-latency evaluator model
module tb_poly_eval_arbiter;

  localparam int N  = 4;
  localparam int IW = 4;
  localparam int OW = 19;
  localparam int TO = 64;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N-1:0]         req;
  logic [N*IW-1:0]      req_x, req_y, req_z;
  logic [N-1:0]         gnt, rsp_valid;
  logic signed [OW-1:0] rsp_data;
  logic                 rsp_err, busy, ev_en;
  logic [IW-1:0]        ev_in0, ev_in1, ev_in2;
  logic                 ev_done = 1'b0;
  logic signed [OW-1:0] ev_out = '0;

  poly_eval_arbiter #(
    .N_REQ(N), .IN_W(IW), .OUT_W(OW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .ev_en(ev_en), .ev_in0(ev_in0), .ev_in1(ev_in1), .ev_in2(ev_in2),
    .ev_done(ev_done), .ev_out(ev_out)
  );

  always #5 clk = ~clk;

  function automatic int poly_f(input int x, input int y, input int z);
    return 5*x*x + 8*x - 4*y*y + 3*y + 6*z*z - 2*z + 13;
  endfunction

  // Evaluator model: done after lat enabled cycles, held until en drops
  int lat_cnt   = 0;
  int lat       = 3;
  int force_lat = 0;
  bit no_done   = 1'b0;

  always @(posedge clk) begin
    if (rst || !ev_en) begin
      ev_done <= 1'b0;
      ev_out  <= OW'($urandom);
      lat_cnt <= 0;
      lat     <= (force_lat != 0) ? force_lat : int'($urandom_range(3, 10));
    end else begin
      lat_cnt <= lat_cnt + 1;
      if (!no_done && !ev_done && (lat_cnt + 1 >= lat)) begin
        ev_done <= 1'b1;
        ev_out  <= OW'(poly_f(int'(ev_in0), int'(ev_in1), int'(ev_in2)));
      end
    end
  end

  typedef struct {
    int r;
    int data;
    bit err;
  } exp_t;

  typedef struct {
    int x;
    int y;
    int z;
    int f;
  } vec_t;

  exp_t exp_q[$];
  int   gnt_log[$];
  int   checks = 0;
  int   errors = 0;
  int   en_cycles = 0;
  bit   prev_done_en = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    int k;
    k = -1;
    for (int i = 0; i < N; i++) if (v[i]) k = i;
    return k;
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (ev_en) en_cycles++;
    if (gnt != '0) begin
      check("gnt_onehot", longint'($onehot(gnt)), 1);
      gnt_log.push_back(idx_of(gnt));
    end
    if (rsp_valid != '0) begin
      check("rsp_onehot", longint'($onehot(rsp_valid)), 1);
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", longint'(rsp_valid), 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_idx", idx_of(rsp_valid), e.r);
        check("rsp_data", longint'(rsp_data), e.data);
        check("rsp_err", longint'(rsp_err), longint'(e.err));
        if (!e.err) check("rsp_latency", longint'(prev_done_en), 1);
      end
    end
    prev_done_en = ev_done && ev_en;
  endtask

  task automatic set_ops(input int r, input int x, input int y, input int z);
    req_x[r*IW +: IW] = IW'(x);
    req_y[r*IW +: IW] = IW'(y);
    req_z[r*IW +: IW] = IW'(z);
  endtask

  task automatic push_exp(input int r, input int data, input bit err);
    exp_t e;
    e.r = r; e.data = data; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic wait_gnt(input logic [N-1:0] mask, output int got);
    int n;
    n = 0;
    got = -1;
    while (got < 0 && n < 50) begin
      tick();
      n++;
      if ((gnt & mask) != '0) got = idx_of(gnt);
    end
    if (got < 0) begin
      checks++;
      errors++;
      $display("FAIL gnt_wait: no grant for mask %b within 50 cycles", mask);
    end
  endtask

  task automatic wait_rsp_done(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      check("rsp_wait", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic collect_grants(input int count, input bit drop_each);
    int n;
    n = 0;
    while (gnt_log.size() < count && n < 1000) begin
      tick();
      n++;
      if (drop_each) req = req & ~gnt;
    end
    req = '0;
  endtask

  vec_t vecs[8];
  int   got;
  int   r;
  int   exp_order[4];

  initial begin
    vecs = '{'{0, 0, 0, 13}, '{1, 0, 0, 26}, '{3, 2, 1, 76}, '{2, 5, 3, 12},
             '{15, 15, 15, 1723}, '{0, 15, 0, -842}, '{0, 0, 15, 1333}, '{7, 9, 4, 105}};
    req_x = '0; req_y = '0; req_z = '0;
    req   = 4'hF;
    rst   = 1'b1;

    // Reset held with all requests up, then all four granted in index order
    set_ops(0, 0, 0, 0); set_ops(1, 1, 0, 0); set_ops(2, 3, 2, 1); set_ops(3, 2, 5, 3);
    push_exp(0, 13, 0); push_exp(1, 26, 0); push_exp(2, 76, 0); push_exp(3, 12, 0);
    repeat (3) begin
      tick();
      check("reset_outputs", longint'({gnt, rsp_valid, rsp_data, rsp_err, busy, ev_en,
                                        ev_in0, ev_in1, ev_in2}), 0);
    end
    rst = 1'b0;
    collect_grants(4, 1'b1);
    wait_rsp_done(500);
    check("burst_grant_count", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++) if (i < gnt_log.size()) check("burst_order", gnt_log[i], i);

    // Single request: grant timing and enable latency
    gnt_log.delete();
    set_ops(0, 1, 0, 0);
    push_exp(0, 26, 0);
    req = 4'b0001;
    wait_gnt(4'b0001, got);
    req = '0;
    check("single_ev_in0", longint'(ev_in0), 1);
    check("single_en_in_gnt", longint'(ev_en), 0);
    tick();
    check("single_en_rise", longint'(ev_en), 1);
    wait_rsp_done(100);

    // Table of vectors, one requester at a time
    for (int i = 0; i < 8; i++) begin
      r = i % N;
      set_ops(r, vecs[i].x, vecs[i].y, vecs[i].z);
      push_exp(r, vecs[i].f, 0);
      req = N'(1) << r;
      wait_gnt(req, got);
      check("vec_gnt", got, r);
      req = '0;
      wait_rsp_done(100);
    end

    // Two requesters held high alternate
    gnt_log.delete();
    set_ops(0, 1, 0, 0); set_ops(2, 3, 2, 1);
    push_exp(0, 26, 0); push_exp(2, 76, 0); push_exp(0, 26, 0); push_exp(2, 76, 0);
    req = 4'b0101;
    collect_grants(4, 1'b0);
    wait_rsp_done(300);
    exp_order = '{0, 2, 0, 2};
    check("alt_grant_count", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++) if (i < gnt_log.size()) check("alt_order", gnt_log[i], exp_order[i]);

    // Evaluator never finishes: timeout abort
    no_done = 1'b1;
    set_ops(1, 4, 4, 4);
    push_exp(1, 0, 1);
    req = 4'b0010;
    wait_gnt(4'b0010, got);
    req = '0;
    en_cycles = 0;
    wait_rsp_done(200);
    check("timeout_en_cycles", en_cycles, TO);
    tick();
    tick();
    check("timeout_back_idle", longint'(busy), 0);
    no_done = 1'b0;

    // Done arriving on the last allowed cycle beats the timeout
    force_lat = TO - 1;
    set_ops(3, 2, 5, 3);
    push_exp(3, 12, 0);
    req = 4'b1000;
    wait_gnt(4'b1000, got);
    req = '0;
    wait_rsp_done(200);
    force_lat = 10;

    // Reset mid-BUSY drops the job and clears the pointer
    set_ops(2, 15, 15, 15);
    req = 4'b0100;
    wait_gnt(4'b0100, got);
    req = '0;
    repeat (3) tick();
    check("midbusy_en_before_rst", longint'(ev_en), 1);
    rst = 1'b1;
    tick();
    check("rst_en_low", longint'(ev_en), 0);
    check("rst_busy_low", longint'(busy), 0);
    rst = 1'b0;
    force_lat = 0;
    repeat (12) tick();
    gnt_log.delete();
    set_ops(1, 15, 15, 15); set_ops(3, 0, 0, 0);
    push_exp(1, 1723, 0); push_exp(3, 13, 0);
    req = 4'b1010;
    collect_grants(2, 1'b1);
    wait_rsp_done(200);
    check("post_rst_grant_count", gnt_log.size(), 2);
    if (gnt_log.size() > 0) check("post_rst_first_gnt", gnt_log[0], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
